guess_checker: RTL and testbench
================================

GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 SHALL have parameter MAX_LIVES, default 6, meaning the misses allowed per word (range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port new_word, input, 1, a load strobe; word and mask are sampled when it is high.
REQ-005 SHALL have port word, input, 30, six 5-bit letter codes; position 0 = word[29:25], position 5 = word[4:0]; codes 0..25 = A..Z; codes 26..31 = pad.
REQ-006 SHALL have port mask, input, 26, where mask[i] = 1 means letter code i occurs in word.
REQ-007 SHALL have port guess_valid, input, 1, meaning a guess is offered.
REQ-008 SHALL have port guess_letter, input, 5, the guessed letter code.
REQ-009 SHALL have port guess_ready, output, 1, meaning a guess can be accepted.
REQ-010 SHALL have port revealed, output, 6, a per-position revealed flag (bit 5 = position 0).
REQ-011 SHALL have port revealed_word, output, 30, which carries the word code where the position is revealed and 5'b11111 elsewhere.
REQ-012 SHALL have port lives_left, output, 3, the remaining misses.
REQ-013 SHALL have port result_valid, output, 1, a one-cycle pulse that qualifies result.
REQ-014 SHALL have port result, output, 2, with 00 = hit, 01 = miss, 10 = repeat, 11 = invalid.
REQ-015 SHALL have port game_won, output, 1, held high while in WON.
REQ-016 SHALL have port lost_game, output, 1, held high while in LOST.
REQ-017 SHALL have port mask_error, output, 1, a sticky flag set when the scan outcome contradicts mask.

Function
REQ-018 SHALL implement the states IDLE, LOAD, WAIT, CHECK, UPDATE, WON and LOST.
REQ-019 SHALL enter LOAD on the next edge whenever new_word = 1 in any state; this overrides all other transitions.
REQ-020 LOAD SHALL latch word and mask, clear the 26-bit guessed set, set revealed[p] = 1 for pad positions only, and set lives_left = MAX_LIVES; next state is WAIT, or WON if all positions are pads.
REQ-021 SHALL drive guess_ready = 1 only in WAIT with new_word = 0; a guess is accepted on an edge where guess_valid & guess_ready.
REQ-022 SHALL, on accept, latch guess_letter and go to CHECK with scan index 0.
REQ-023 CHECK SHALL examine one position per cycle, indices 0..5; on a match with an unrevealed position it sets that revealed bit and records a hit; after index 5 the next state is UPDATE.
REQ-024 SHALL make the CHECK decision as follows: a code >25 gives invalid; a code already in the guessed set gives repeat; in both cases no positions change.
REQ-025 SHALL pulse result_valid in UPDATE, exactly 7 cycles after the accepting edge.
REQ-026 UPDATE SHALL add the letter to the guessed set (valid codes only).
REQ-027 On a miss, UPDATE SHALL decrement lives_left, saturating at 0.
REQ-028 After UPDATE the next state SHALL be LOST if lives_left has reached 0, WON if all revealed bits are 1, and WAIT otherwise.
REQ-029 Invalid and repeat results SHALL NOT change lives_left.
REQ-030 SHALL set mask_error when a hit occurs with mask[letter] = 0, or a miss occurs with mask[letter] = 1; the flag clears only in LOAD or on reset.
REQ-031 WON and LOST SHALL be absorbing until new_word; guess_ready = 0 in both.
REQ-032 A new_word asserted mid-CHECK SHALL abandon the scan with no result_valid pulse.
REQ-033 revealed_word SHALL be combinational from the latched word and revealed.

Reset
REQ-034 SHALL, on resetn low, enter IDLE immediately; all outputs go to 0 except revealed_word, which is 30'h3FFFFFFF; latched word, mask and guessed set clear.
REQ-035 IDLE SHALL leave only via new_word.

Structure
REQ-036 SHALL take state encoding, the result codes, LETTER_W = 5, NUM_POS = 6, PAD_MIN = 26 and BLANK = 5'b11111 from shared package hangman_pkg.
REQ-037 SHALL place the guessed-letter bookkeeping in one sub-module, letter_set: a 26-bit register with clear, test(letter) and set(letter).

Verification
REQ-038 Load HELLO+pad (7,4,11,11,14,31) -> revealed=000001, lives_left=6, guess_ready=1 one cycle after LOAD.
REQ-039 Guess L(11) -> result=hit at accept+7, revealed=001101; guess L again -> result=repeat, lives_left stays 6.
REQ-040 Guess 30 -> result=invalid, lives_left and revealed unchanged.
REQ-041 With MAX_LIVES=2, guess Z and then Q -> results miss, miss; lives_left 2→1→0; lost_game=1; guess_ready=0.
REQ-042 Guess H, E, L, O -> game_won=1 after the final UPDATE; then new_word -> game_won=0 and lives_left reloaded.
REQ-043 Assert new_word during CHECK -> no result_valid pulse and state reloads; separately, drop resetn mid-CHECK -> outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/hangman_pkg.sv
// -----------------------------------------------------------------------------
// hangman_pkg
// Shared definitions for the guess checker: word geometry, letter coding,
// FSM state encoding, result codes and small word-slicing helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package hangman_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_POS     = 6;
  localparam int NUM_LETTERS = 26;
  localparam int WORD_W      = LETTER_W * NUM_POS;

  // Codes at or above PAD_MIN are padding, never real letters.
  localparam logic [LETTER_W-1:0] PAD_MIN = 5'd26;
  // Shown in place of an unrevealed position.
  localparam logic [LETTER_W-1:0] BLANK   = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_UPDATE,
    S_WON,
    S_LOST
  } state_t;

  typedef enum logic [1:0] {
    RES_HIT     = 2'b00,
    RES_MISS    = 2'b01,
    RES_REPEAT  = 2'b10,
    RES_INVALID = 2'b11
  } result_t;

  // Letter code at position p (position 0 sits in the top bits of the word).
  function automatic logic [LETTER_W-1:0] pos_code(input logic [WORD_W-1:0] w,
                                                   input int p);
    return LETTER_W'(w >> ((NUM_POS - 1 - p) * LETTER_W));
  endfunction

  // One flag per position that holds a pad code; bit NUM_POS-1 = position 0.
  function automatic logic [NUM_POS-1:0] pad_positions(input logic [WORD_W-1:0] w);
    logic [NUM_POS-1:0] r;
    logic [WORD_W-1:0]  t;
    r = '0;
    t = w;
    for (int p = 0; p < NUM_POS; p++) begin
      r = {r[NUM_POS-2:0], t[WORD_W-1 -: LETTER_W] >= PAD_MIN};
      t = t << LETTER_W;
    end
    return r;
  endfunction

endpackage

// File: rtl/letter_set.sv
// -----------------------------------------------------------------------------
// letter_set
// Set of already-guessed letters, one bit per letter code 0..25.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : synchronous clear of the whole set (wins over set_en)
//   set_en      : add 'letter' to the set (codes >= 26 are ignored)
//   letter      : letter to test and/or add
//   present     : 'letter' is already in the set (always 0 for pad codes)
// -----------------------------------------------------------------------------
module letter_set
  import hangman_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                set_en,
  input  logic [LETTER_W-1:0] letter,
  output logic                present
);

  logic [NUM_LETTERS-1:0] bits;
  logic [31:0]            bits_ext;
  logic [31:0]            letter_onehot;

  // Widening to 32 entries makes every 5-bit code a legal index; pad codes
  // land on the zero-filled upper bits, so they never test present or get set.
  assign bits_ext      = {{(32 - NUM_LETTERS){1'b0}}, bits};
  assign letter_onehot = 32'd1 << letter;
  assign present       = bits_ext[letter];

  // NOTE: this register array is small and must read empty after reset, so it
  // gets a real reset; large RAM-style storage would normally be left unreset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bits <= '0;
    end else if (clear) begin
      bits <= '0;
    end else if (set_en) begin
      bits <= bits | letter_onehot[NUM_LETTERS-1:0];
    end
  end

endmodule

// File: rtl/guess_checker.sv
// -----------------------------------------------------------------------------
// guess_checker
// Hangman guess engine. A word of six 5-bit codes is loaded with its letter
// mask; each accepted guess is scanned across the positions one per cycle and
// a hit/miss/repeat/invalid result is pulsed 7 cycles after acceptance.
//   clk, resetn    : clock, asynchronous active-low reset
//   new_word       : load strobe, overrides every state
//   word, mask     : word codes (position 0 = word[29:25]) and letter mask
//   guess_valid    : guess offered; guess_letter is the guessed code
//   guess_ready    : guess can be accepted this cycle
//   revealed       : per-position revealed flag (bit 5 = position 0)
//   revealed_word  : word codes where revealed, BLANK elsewhere
//   lives_left     : remaining misses
//   result_valid   : one-cycle pulse qualifying result
//   result         : hit / miss / repeat / invalid
//   game_won/lost_game : held while the game is won / lost
//   mask_error     : sticky, scan outcome contradicted the loaded mask
// -----------------------------------------------------------------------------
module guess_checker
  import hangman_pkg::*;
#(
  parameter int MAX_LIVES = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                new_word,
  input  logic [WORD_W-1:0]   word,
  input  logic [NUM_LETTERS-1:0] mask,
  input  logic                guess_valid,
  input  logic [LETTER_W-1:0] guess_letter,
  output logic                guess_ready,
  output logic [NUM_POS-1:0]  revealed,
  output logic [WORD_W-1:0]   revealed_word,
  output logic [2:0]          lives_left,
  output logic                result_valid,
  output logic [1:0]          result,
  output logic                game_won,
  output logic                lost_game,
  output logic                mask_error
);

  state_t                 state;
  logic [WORD_W-1:0]      word_q;
  logic [NUM_LETTERS-1:0] mask_q;
  logic [LETTER_W-1:0]    guess_q;
  logic [2:0]             idx;
  logic                   hit_q;

  logic                   already_guessed;
  logic                   scorable;
  logic                   mask_bit;
  logic [31:0]            mask_ext;
  logic [LETTER_W-1:0]    scan_code;
  logic [NUM_POS-1:0]     scan_onehot;
  logic [2:0]             lives_after;
  result_t                upd_result;

  letter_set u_letter_set (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (new_word),
    .set_en  (state == S_UPDATE),
    .letter  (guess_q),
    .present (already_guessed)
  );

  assign guess_ready = (state == S_WAIT) && !new_word;

  // Only a fresh, in-range letter may reveal positions or cost a life.
  assign scorable    = (guess_q < PAD_MIN) && !already_guessed;
  assign mask_ext    = {{(32 - NUM_LETTERS){1'b0}}, mask_q};
  assign mask_bit    = mask_ext[guess_q];
  assign scan_code   = pos_code(word_q, int'(idx));
  assign scan_onehot = NUM_POS'(1 << (NUM_POS - 1)) >> idx;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    upd_result = RES_HIT;
    if (guess_q >= PAD_MIN) begin
      upd_result = RES_INVALID;
    end else if (already_guessed) begin
      upd_result = RES_REPEAT;
    end else if (!hit_q) begin
      upd_result = RES_MISS;
    end
  end

  always_comb begin
    lives_after = lives_left;
    if (upd_result == RES_MISS && lives_left != 3'd0) begin
      lives_after = lives_left - 3'd1;
    end
  end

  // Walk the positions from 0 upward, consuming the top bits of the copies.
  always_comb begin
    logic [NUM_POS-1:0] r_tmp;
    logic [WORD_W-1:0]  w_tmp;
    revealed_word = '1;
    r_tmp         = revealed;
    w_tmp         = word_q;
    for (int p = 0; p < NUM_POS; p++) begin
      revealed_word = {revealed_word[WORD_W-LETTER_W-1:0],
                       r_tmp[NUM_POS-1] ? w_tmp[WORD_W-1 -: LETTER_W] : BLANK};
      r_tmp = r_tmp << 1;
      w_tmp = w_tmp << LETTER_W;
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      word_q       <= '0;
      mask_q       <= '0;
      guess_q      <= '0;
      idx          <= '0;
      hit_q        <= 1'b0;
      revealed     <= '0;
      lives_left   <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      game_won     <= 1'b0;
      lost_game    <= 1'b0;
      mask_error   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (new_word) begin
        // Loading is done on the edge that enters LOAD so the fresh word is
        // visible on the outputs during the LOAD cycle itself.
        state      <= S_LOAD;
        word_q     <= word;
        mask_q     <= mask;
        revealed   <= pad_positions(word);
        lives_left <= 3'(MAX_LIVES);
        idx        <= '0;
        hit_q      <= 1'b0;
        game_won   <= 1'b0;
        lost_game  <= 1'b0;
        mask_error <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (&revealed) begin
              state    <= S_WON;
              game_won <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (guess_valid) begin
              guess_q <= guess_letter;
              idx     <= '0;
              hit_q   <= 1'b0;
              state   <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (scorable && scan_code == guess_q && (revealed & scan_onehot) == '0) begin
              revealed <= revealed | scan_onehot;
              hit_q    <= 1'b1;
            end
            if (idx == 3'(NUM_POS - 1)) begin
              state <= S_UPDATE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          S_UPDATE: begin
            result_valid <= 1'b1;
            result       <= upd_result;
            lives_left   <= lives_after;
            if ((upd_result == RES_HIT && !mask_bit) ||
                (upd_result == RES_MISS && mask_bit)) begin
              mask_error <= 1'b1;
            end
            if (lives_after == 3'd0) begin
              state     <= S_LOST;
              lost_game <= 1'b1;
            end else if (&revealed) begin
              state    <= S_WON;
              game_won <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WON, S_LOST: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_checker.sv
// -----------------------------------------------------------------------------
// tb_guess_checker
// Two instances: index 0 with the default lives, index 1 with MAX_LIVES = 2.
// A behavioural model per instance tracks the word, revealed positions,
// guessed letters and lives using plain arrays and the game rules.
// -----------------------------------------------------------------------------
module tb_guess_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        nw[2];
  logic [29:0] wd[2];
  logic [25:0] mk[2];
  logic        gv[2];
  logic [4:0]  gl[2];
  logic        gr[2];
  logic [5:0]  rev[2];
  logic [29:0] rw[2];
  logic [2:0]  ll[2];
  logic        rvld[2];
  logic [1:0]  res[2];
  logic        won[2];
  logic        lost[2];
  logic        merr[2];

  always #5 clk = ~clk;

  guess_checker u_dut0 (
    .clk(clk), .resetn(resetn), .new_word(nw[0]), .word(wd[0]), .mask(mk[0]),
    .guess_valid(gv[0]), .guess_letter(gl[0]), .guess_ready(gr[0]),
    .revealed(rev[0]), .revealed_word(rw[0]), .lives_left(ll[0]),
    .result_valid(rvld[0]), .result(res[0]), .game_won(won[0]),
    .lost_game(lost[0]), .mask_error(merr[0])
  );

  guess_checker #(.MAX_LIVES(2)) u_dut1 (
    .clk(clk), .resetn(resetn), .new_word(nw[1]), .word(wd[1]), .mask(mk[1]),
    .guess_valid(gv[1]), .guess_letter(gl[1]), .guess_ready(gr[1]),
    .revealed(rev[1]), .revealed_word(rw[1]), .lives_left(ll[1]),
    .result_valid(rvld[1]), .result(res[1]), .game_won(won[1]),
    .lost_game(lost[1]), .mask_error(merr[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int        m_code[2][6];
  bit        m_rev[2][6];
  bit [25:0] m_mask[2];
  bit [25:0] m_guessed[2];
  int        m_lives[2];
  int        m_max[2];
  bit        m_won[2];
  bit        m_lost[2];
  bit        m_merr[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] exp_revealed(input int i);
    logic [5:0] r;
    r = '0;
    for (int p = 0; p < 6; p++) r = {r[4:0], m_rev[i][p]};
    return r;
  endfunction

  function automatic logic [29:0] exp_word(input int i);
    logic [29:0] w;
    w = '0;
    for (int p = 0; p < 6; p++) w = {w[24:0], m_rev[i][p] ? 5'(m_code[i][p]) : 5'h1f};
    return w;
  endfunction

  function automatic bit all_revealed(input int i);
    bit a;
    a = 1'b1;
    for (int p = 0; p < 6; p++) a &= m_rev[i][p];
    return a;
  endfunction

  task automatic model_reset(input int i);
    for (int p = 0; p < 6; p++) begin
      m_code[i][p] = 0;
      m_rev[i][p]  = 1'b0;
    end
    m_mask[i] = '0; m_guessed[i] = '0; m_lives[i] = 0;
    m_won[i] = 1'b0; m_lost[i] = 1'b0; m_merr[i] = 1'b0;
  endtask

  task automatic check_state(input int i, input string tag);
    check($sformatf("%s_revealed%0d", tag, i), rev[i], exp_revealed(i));
    check($sformatf("%s_word%0d", tag, i), rw[i], exp_word(i));
    check($sformatf("%s_lives%0d", tag, i), ll[i], m_lives[i]);
    check($sformatf("%s_won%0d", tag, i), won[i], m_won[i]);
    check($sformatf("%s_lost%0d", tag, i), lost[i], m_lost[i]);
    check($sformatf("%s_merr%0d", tag, i), merr[i], m_merr[i]);
  endtask

  task automatic check_reset(input int i, input string tag);
    check_state(i, tag);
    check($sformatf("%s_rw_all_ones%0d", tag, i), rw[i], 30'h3FFFFFFF);
    check($sformatf("%s_ready%0d", tag, i), gr[i], 1'b0);
    check($sformatf("%s_rvalid%0d", tag, i), rvld[i], 1'b0);
    check($sformatf("%s_result%0d", tag, i), res[i], 2'b00);
  endtask

  // Called at #1 after a rising edge.
  task automatic load(input int i, input logic [29:0] w, input logic [25:0] m);
    logic [29:0] t;
    nw[i] = 1'b1; wd[i] = w; mk[i] = m;
    @(posedge clk); #1;
    nw[i] = 1'b0;
    t = w;
    for (int p = 0; p < 6; p++) begin
      m_code[i][p] = int'(t[29:25]);
      m_rev[i][p]  = (m_code[i][p] >= 26);
      t = t << 5;
    end
    m_mask[i] = m; m_guessed[i] = '0; m_lives[i] = m_max[i];
    m_won[i] = 1'b0; m_lost[i] = 1'b0; m_merr[i] = 1'b0;
    check_state(i, "load");
    @(posedge clk); #1;
    m_won[i] = all_revealed(i);
    check($sformatf("load_won%0d", i), won[i], m_won[i]);
    check($sformatf("load_ready%0d", i), gr[i], !m_won[i]);
  endtask

  task automatic accept(input int i, input logic [4:0] l, output bit ok);
    for (int k = 0; k < 20 && !gr[i]; k++) begin
      @(posedge clk); #1;
    end
    check($sformatf("accept_ready%0d", i), gr[i], 1'b1);
    ok = gr[i];
    if (!ok) return;
    gv[i] = 1'b1; gl[i] = l;
    @(posedge clk); #1;
    gv[i] = 1'b0;
  endtask

  // Returns the result code the model expects.
  task automatic guess(input int i, input logic [4:0] l, output logic [1:0] exp_res);
    bit ok;
    bit hit;
    int n;
    int li;
    li = int'(l);
    if (li > 25) exp_res = 2'b11;
    else if (m_guessed[i][li]) exp_res = 2'b10;
    else begin
      hit = 1'b0;
      for (int p = 0; p < 6; p++) begin
        if (m_code[i][p] == li && !m_rev[i][p]) begin
          m_rev[i][p] = 1'b1;
          hit = 1'b1;
        end
      end
      exp_res = hit ? 2'b00 : 2'b01;
      if (!hit && m_lives[i] > 0) m_lives[i]--;
      if ((hit && !m_mask[i][li]) || (!hit && m_mask[i][li])) m_merr[i] = 1'b1;
      m_guessed[i][li] = 1'b1;
      if (m_lives[i] == 0) m_lost[i] = 1'b1;
      else if (all_revealed(i)) m_won[i] = 1'b1;
    end
    accept(i, l, ok);
    if (!ok) return;
    n = 0;
    while (!rvld[i] && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency%0d_l%0d", i, li), n, 7);
    check($sformatf("result%0d_l%0d", i, li), res[i], exp_res);
    check_state(i, "guess");
    check($sformatf("post_ready%0d", i), gr[i], !(m_won[i] || m_lost[i]));
    @(posedge clk); #1;
    check($sformatf("pulse_one_cycle%0d", i), rvld[i], 1'b0);
  endtask

  localparam logic [29:0] HELLO = {5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd31};
  localparam logic [25:0] HELLO_MASK = 26'(1 << 7) | 26'(1 << 4) | 26'(1 << 11) | 26'(1 << 14);

  initial begin
    logic [1:0]  r;
    logic [29:0] w;
    logic [25:0] m;
    bit          ok;
    bit          seen;
    int          inst;
    int          c;

    m_max[0] = 6; m_max[1] = 2;
    for (int i = 0; i < 2; i++) begin
      nw[i] = 1'b0; wd[i] = '0; mk[i] = '0; gv[i] = 1'b0; gl[i] = '0;
      model_reset(i);
    end
    resetn = 1'b0;
    #12;
    check_reset(0, "rst");
    check_reset(1, "rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_stays0", gr[0], 1'b0);

    // HELLO on the default instance.
    load(0, HELLO, HELLO_MASK);
    check("hello_revealed", rev[0], 6'b000001);
    check("hello_lives", ll[0], 3'd6);
    guess(0, 5'd11, r);
    check("l_revealed", rev[0], 6'b001101);
    guess(0, 5'd11, r);
    check("l_again_lives", ll[0], 3'd6);
    guess(0, 5'd30, r);
    check("invalid_revealed", rev[0], 6'b001101);
    guess(0, 5'd7, r);
    guess(0, 5'd4, r);
    guess(0, 5'd11, r);
    guess(0, 5'd14, r);
    check("hello_won", won[0], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("won_absorbing", won[0], 1'b1);
    check("won_not_ready", gr[0], 1'b0);
    load(0, HELLO, HELLO_MASK);
    check("reload_won_clear", won[0], 1'b0);
    check("reload_lives", ll[0], 3'd6);

    // Two misses exhaust the short-lived instance.
    load(1, HELLO, HELLO_MASK);
    guess(1, 5'd25, r);
    check("z_lives", ll[1], 3'd1);
    guess(1, 5'd16, r);
    check("q_lives", ll[1], 3'd0);
    check("q_lost", lost[1], 1'b1);
    gv[1] = 1'b1; gl[1] = 5'd7;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= rvld[1];
    end
    gv[1] = 1'b0;
    check("lost_no_result", seen, 1'b0);
    check("lost_absorbing", lost[1], 1'b1);
    check("lost_not_ready", gr[1], 1'b0);

    // new_word in the middle of a scan abandons it.
    accept(0, 5'd7, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    w = {5'd0, 5'd1, 5'd2, 5'd28, 5'd3, 5'd4};
    m = 26'h1F;
    load(0, w, m);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen |= rvld[0];
    end
    check("abandon_no_pulse", seen, 1'b0);
    check_state(0, "abandon");

    // Asynchronous reset in the middle of a scan.
    accept(0, 5'd2, ok);
    @(posedge clk); #1;
    #2;
    resetn = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_reset(0, "async_rst");
    check_reset(1, "async_rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Randomised games on either instance.
    for (int g = 0; g < 14; g++) begin
      inst = int'($urandom_range(0, 1));
      w = '0;
      m = '0;
      for (int p = 0; p < 6; p++) begin
        if ($urandom_range(0, 5) == 0) c = int'($urandom_range(26, 31));
        else c = int'($urandom_range(0, 25));
        w = {w[24:0], 5'(c)};
        if (c < 26) m = m | (26'd1 << c);
      end
      if ($urandom_range(0, 3) == 0) m = m ^ (26'd1 << $urandom_range(0, 25));
      load(inst, w, m);
      for (int k = 0; k < 14 && !m_won[inst] && !m_lost[inst]; k++) begin
        if ($urandom_range(0, 9) < 7) c = m_code[inst][$urandom_range(0, 5)];
        else c = int'($urandom_range(0, 31));
        guess(inst, 5'(c), r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a bounded wait was somehow bypassed.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
